bcd2bin16: RTL and testbench

Sequential BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from any digit ≥ 8. It takes five BCD digits (the clock's displayed or user-set value) and produces an unsigned binary word of `DATA_WIDTH` bits. It sits on the set/adjust path, where keypad or button-entered decimal values are turned back into binary counters. It flags digit values above 9 and results that do not fit in `DATA_WIDTH`.

---
 rtl/bcd2bin16.sv | 108 ++++++++++
 tb/tb_bcd2bin16.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bcd2bin16.sv
// Sequential BCD-to-binary converter (reverse double dabble) for five BCD digits.
// Flags digits above 9 and results that do not fit in DATA_WIDTH bits.
module bcd2bin16 #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  en,
   input  logic [3:0]            bcd0,
   input  logic [3:0]            bcd1,
   input  logic [3:0]            bcd2,
   input  logic [3:0]            bcd3,
   input  logic [3:0]            bcd4,
   output logic [DATA_WIDTH-1:0] bin,
   output logic                  ovf,
   output logic                  err,
   output logic                  busy,
   output logic                  fin
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      FIN  = 2'b10
   } state_t;

   state_t      state, state_next;
   logic [4:0]  bitcount;
   logic [19:0] digits;
   logic [19:0] acc;

   logic [19:0] sh_digits, corr_digits, sh_acc;
   logic        digit_err;
   logic        acc_hi;

   assign digit_err = (bcd0 > 4'd9) | (bcd1 > 4'd9) | (bcd2 > 4'd9) |
                      (bcd3 > 4'd9) | (bcd4 > 4'd9);

   // One reverse double-dabble step: shift {digits, acc} right, then fix every nibble >= 8.
   always_comb begin
      sh_digits   = {1'b0, digits[19:1]};
      sh_acc      = {digits[0], acc[19:1]};
      corr_digits = sh_digits;
      for (int i = 0; i < 5; i++) begin
         if (sh_digits[4*i+3])
            corr_digits[4*i +: 4] = sh_digits[4*i +: 4] - 4'd3;
      end
   end

   generate
      if (DATA_WIDTH < 20) begin : g_ovf
         assign acc_hi = |sh_acc[19:DATA_WIDTH];
      end else begin : g_no_ovf
         assign acc_hi = 1'b0;
      end
   endgenerate

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:    state_next = en ? BUSY : IDLE;
         BUSY:    state_next = (bitcount == 5'd19) ? FIN : BUSY;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         bitcount <= '0;
         digits   <= '0;
         acc      <= '0;
         bin      <= '0;
         ovf      <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (en) begin
                  digits   <= {bcd4, bcd3, bcd2, bcd1, bcd0};
                  acc      <= '0;
                  bitcount <= '0;
                  err      <= digit_err;
                  ovf      <= 1'b0;
               end
            end
            BUSY: begin
               digits   <= corr_digits;
               acc      <= sh_acc;
               bitcount <= bitcount + 5'd1;
               if (bitcount == 5'd19) begin
                  bin <= err ? '0 : sh_acc[DATA_WIDTH-1:0];
                  ovf <= err ? 1'b0 : acc_hi;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign fin  = (state == FIN);

endmodule

// File: tb/tb_bcd2bin16.sv
// Directed self-checking bench for bcd2bin16: a 16-bit instance plus a 20-bit
// instance sharing the same stimulus.
module tb_bcd2bin16;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        en  = 1'b0;
   logic [3:0]  bcd0 = '0, bcd1 = '0, bcd2 = '0, bcd3 = '0, bcd4 = '0;

   logic [15:0] bin;
   logic        ovf, err, busy, fin;
   logic [19:0] bin20;
   logic        ovf20, err20, busy20, fin20;

   int checks = 0;
   int passed = 0;
   int cycle  = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cycle++;

   bcd2bin16 #(.DATA_WIDTH(16)) dut (
      .CLK(CLK), .RST(RST), .en(en),
      .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4),
      .bin(bin), .ovf(ovf), .err(err), .busy(busy), .fin(fin)
   );

   bcd2bin16 #(.DATA_WIDTH(20)) dut20 (
      .CLK(CLK), .RST(RST), .en(en),
      .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4),
      .bin(bin20), .ovf(ovf20), .err(err20), .busy(busy20), .fin(fin20)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic set_digits(input logic [3:0] d4, d3, d2, d1, d0);
      bcd4 = d4; bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
   endtask

   // en is driven for one cycle and accepted on the following edge (A).
   // Step n counts negedges after A; fin must appear at n = 20 only and busy covers n = 0..20.
   task automatic convert(input string tag, input logic [3:0] d4, d3, d2, d1, d0,
                          input logic [15:0] exp_bin, input logic exp_ovf, input logic exp_err);
      int fin_at, fin_cnt;
      logic busy_ok;
      @(negedge CLK);
      set_digits(d4, d3, d2, d1, d0);
      en = 1'b1;
      @(posedge CLK);
      #1 en = 1'b0;
      fin_at  = -1;
      fin_cnt = 0;
      busy_ok = 1'b1;
      @(negedge CLK);
      check({tag, " err early"}, {31'd0, err}, {31'd0, exp_err});
      for (int n = 0; n <= 22; n++) begin
         if (n > 0) @(negedge CLK);
         if (fin) begin
            fin_cnt++;
            if (fin_at < 0) fin_at = n;
         end
         if (busy !== (n <= 20)) busy_ok = 1'b0;
      end
      check({tag, " fin step"}, fin_at, 32'd20);
      check({tag, " fin width"}, fin_cnt, 32'd1);
      check({tag, " busy window"}, {31'd0, busy_ok}, 32'd1);
      check({tag, " bin"}, {16'd0, bin}, {16'd0, exp_bin});
      check({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
      check({tag, " err hold"}, {31'd0, err}, {31'd0, exp_err});
   endtask

   task automatic wait_fin(input string tag, output int at_cycle);
      at_cycle = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge CLK);
         if (fin) begin
            at_cycle = cycle;
            break;
         end
      end
      if (at_cycle < 0) check({tag, " fin timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int c1, c2;

      repeat (2) @(negedge CLK);
      check("reset bin", {16'd0, bin}, 32'd0);
      check("reset busy/fin/err/ovf", {28'd0, busy, fin, err, ovf}, 32'd0);
      RST = 1'b1;

      convert("zero",  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0);
      convert("12345", 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 16'h3039, 1'b0, 1'b0);
      convert("65535", 4'd6, 4'd5, 4'd5, 4'd3, 4'd5, 16'hFFFF, 1'b0, 1'b0);
      convert("65536", 4'd6, 4'd5, 4'd5, 4'd3, 4'd6, 16'h0000, 1'b1, 1'b0);
      convert("99999", 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 16'h869F, 1'b1, 1'b0);
      check("w20 99999 bin", {12'd0, bin20}, 32'h1869F);
      check("w20 99999 ovf", {31'd0, ovf20}, 32'd0);
      convert("bad digit", 4'd0, 4'd0, 4'hA, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1);
      repeat (3) @(negedge CLK);
      check("err held idle", {31'd0, err}, 32'd1);

      // en held high: the second request starts only after the first finishes.
      @(negedge CLK);
      set_digits(4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
      en = 1'b1;
      @(posedge CLK);
      #1 set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd7);
      wait_fin("hold 42", c1);
      check("hold 42 bin", {16'd0, bin}, 32'd42);
      check("hold 42 err", {31'd0, err}, 32'd0);
      wait_fin("hold 7", c2);
      check("hold 7 bin", {16'd0, bin}, 32'd7);
      check("hold spacing", c2 - c1, 32'd22);
      en = 1'b0;
      repeat (3) @(negedge CLK);

      // Asynchronous reset in the middle of a conversion.
      @(negedge CLK);
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
      en = 1'b1;
      @(posedge CLK);
      #1 en = 1'b0;
      repeat (10) @(posedge CLK);
      #2 RST = 1'b0;
      #1;
      check("mid reset bin", {16'd0, bin}, 32'd0);
      check("mid reset flags", {28'd0, busy, fin, err, ovf}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      convert("after rst 100", 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 16'h0064, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
